// File: rtl/v_hier_iosig_link.sv
// -----------------------------------------------------------------------------
// v_hier_iosig_link
//
// Half-duplex byte link controller sitting directly behind the 3-bit
// bidirectional iosig pads. Outgoing bytes are serialised as four strobed
// dibits, MSB dibit first, followed by a one-cycle strobe-low terminator
// (TAIL) and a bus-release gap (TURN). Incoming bytes are assembled from four
// consecutive strobed dibits driven by the far end.
//
// Parameters:
//   TURN_CYC   bus-release cycles after a transmission (1..15)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   tx_data    byte to transmit
//   tx_valid   tx_data valid
//   tx_ready   combinational; transfer on tx_valid && tx_ready
//   rx_data    last received byte, held until the next reception
//   rx_valid   one-cycle pulse when rx_data is updated
//   rx_err     one-cycle pulse when a reception is aborted
//   busy       state is not IDLE
//   drive      registered output enable for iosig
//   iosig      [2] strobe, [1:0] dibit; released (z) while drive is low
// -----------------------------------------------------------------------------
module v_hier_iosig_link #(
    parameter int TURN_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy,
    output logic       drive,
    inout  wire  [2:0] iosig
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_TX,
        ST_TAIL,
        ST_TURN
    } state_t;

    // TURN is entered with the counter preloaded so that it spends exactly
    // TURN_CYC cycles there before returning to IDLE.
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 1);

    state_t     state_reg;
    logic [1:0] cnt_reg;
    logic [3:0] turn_cnt_reg;
    logic [7:0] shift_reg;
    logic [2:0] pins_reg;
    logic       drive_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       rx_err_reg;

    logic       strobe;
    logic [1:0] dibit;

    // Only a solid 1 counts as a strobe; a floating or unknown pin reads as
    // no strobe, so an idle released bus never starts a reception.
    assign strobe = (iosig[2] === 1'b1);
    assign dibit  = iosig[1:0];

    // Pin value and enable come straight from registers.
    assign iosig = drive_reg ? pins_reg : 3'bzzz;

    // A strobe seen in IDLE wins over a pending transmit request.
    assign tx_ready = (state_reg == ST_IDLE) && !strobe;
    assign busy     = (state_reg != ST_IDLE);
    assign drive    = drive_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_err   = rx_err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 2'd0;
            turn_cnt_reg <= 4'd0;
            shift_reg    <= 8'd0;
            pins_reg     <= 3'b000;
            drive_reg    <= 1'b0;
            rx_data_reg  <= 8'd0;
            rx_valid_reg <= 1'b0;
            rx_err_reg   <= 1'b0;
        end else begin
            // Status pulses last a single cycle.
            rx_valid_reg <= 1'b0;
            rx_err_reg   <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    drive_reg <= 1'b0;
                    pins_reg  <= 3'b000;
                    if (strobe) begin
                        // First dibit of an incoming byte.
                        shift_reg <= {6'd0, dibit};
                        cnt_reg   <= 2'd1;
                        state_reg <= ST_RX;
                    end else if (tx_valid) begin
                        // The first dibit goes onto the pins right away; the
                        // remaining three are kept left-aligned in shift_reg.
                        shift_reg <= {tx_data[5:0], 2'b00};
                        pins_reg  <= {1'b1, tx_data[7:6]};
                        drive_reg <= 1'b1;
                        cnt_reg   <= 2'd0;
                        state_reg <= ST_TX;
                    end
                end

                ST_RX: begin
                    if (strobe) begin
                        if (cnt_reg == 2'd3) begin
                            rx_data_reg  <= {shift_reg[5:0], dibit};
                            rx_valid_reg <= 1'b1;
                            shift_reg    <= 8'd0;
                            cnt_reg      <= 2'd0;
                            state_reg    <= ST_IDLE;
                        end else begin
                            shift_reg <= {shift_reg[5:0], dibit};
                            cnt_reg   <= cnt_reg + 2'd1;
                        end
                    end else begin
                        // Strobe dropped mid-byte: throw the partial byte away.
                        rx_err_reg <= 1'b1;
                        shift_reg  <= 8'd0;
                        cnt_reg    <= 2'd0;
                        state_reg  <= ST_IDLE;
                    end
                end

                ST_TX: begin
                    drive_reg <= 1'b1;
                    if (cnt_reg == 2'd3) begin
                        // Last dibit has been on the pins; terminate with an
                        // explicit strobe-low cycle before letting go.
                        pins_reg  <= 3'b000;
                        cnt_reg   <= 2'd0;
                        state_reg <= ST_TAIL;
                    end else begin
                        pins_reg  <= {1'b1, shift_reg[7:6]};
                        shift_reg <= {shift_reg[5:0], 2'b00};
                        cnt_reg   <= cnt_reg + 2'd1;
                    end
                end

                ST_TAIL: begin
                    drive_reg    <= 1'b0;
                    pins_reg     <= 3'b000;
                    turn_cnt_reg <= TURN_LOAD;
                    state_reg    <= ST_TURN;
                end

                ST_TURN: begin
                    drive_reg <= 1'b0;
                    if (turn_cnt_reg == 4'd0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        turn_cnt_reg <= turn_cnt_reg - 4'd1;
                    end
                end

                default: begin
                    drive_reg <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v_hier_iosig_link.sv
// -----------------------------------------------------------------------------
// Testbench for v_hier_iosig_link. Acts as the far end of the iosig bus and as
// the core-side user, checking pin waveforms, handshake timing and receive
// results against expectations computed from the byte/dibit wire format.
// -----------------------------------------------------------------------------
module tb_v_hier_iosig_link;

    localparam int TURN_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    wire        tx_ready;
    wire  [7:0] rx_data;
    wire        rx_valid;
    wire        rx_err;
    wire        busy;
    wire        drive;
    wire  [2:0] iosig;

    logic       far_drive = 1'b0;
    logic [2:0] far_pins = 3'b000;

    assign iosig = far_drive ? far_pins : 3'bzzz;

    v_hier_iosig_link #(.TURN_CYC(TURN_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .busy     (busy),
        .drive    (drive),
        .iosig    (iosig)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: last byte the far end successfully delivered.
    logic [7:0] last_rx = 8'd0;
    logic [7:0] rxq [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Dibit i (0 = first on the wire) of byte b, MSB first.
    function automatic logic [1:0] dib(input logic [7:0] b, input int i);
        logic [7:0] s;
        s = b >> (6 - 2 * i);
        return s[1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle right after the handshake edge; follows the whole
    // TX / TAIL / TURN sequence and ends in the first IDLE cycle.
    task automatic tx_observe(input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tx_drive", 32'(drive), 32'(1'b1));
            chk("tx_pins", 32'(iosig), 32'({1'b1, dib(b, i)}));
            chk("tx_busy", 32'(busy), 32'(1'b1));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("tail_drive", 32'(drive), 32'(1'b1));
        chk("tail_pins", 32'(iosig), 32'(3'b000));
        for (int t = 0; t < TURN_CYC; t++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("turn_drive", 32'(drive), 32'(1'b0));
            chk("turn_ready", 32'(tx_ready), 32'(1'b0));
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("tx_ready_back", 32'(tx_ready), 32'(1'b1));
        chk("tx_idle", 32'(busy), 32'(1'b0));
    endtask

    task automatic tx_byte(input logic [7:0] b);
        step();
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("tx_ready", 32'(tx_ready), 32'(1'b1));
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tx_observe(b);
    endtask

    // Far end sends rxq[0..n-1] back to back; ends in the rx_valid cycle of
    // the last byte.
    task automatic rx_stream(input int n);
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < 4; i++) begin
                far_drive = 1'b1;
                far_pins  = {1'b1, dib(rxq[j], i)};
                @(negedge clk);
                if (j == 0 && i == 0)
                    chk("rx_strobe_blocks_tx", 32'(tx_ready), 32'(1'b0));
                if (i == 0 && j > 0) begin
                    chk("rx_valid_b2b", 32'(rx_valid), 32'(1'b1));
                    chk("rx_data_b2b", 32'(rx_data), 32'(rxq[j-1]));
                end else begin
                    chk("rx_valid_quiet", 32'(rx_valid), 32'(1'b0));
                end
                chk("rx_err_quiet", 32'(rx_err), 32'(1'b0));
                @(posedge clk);
                #1;
            end
        end
        far_drive = 1'b0;
        @(negedge clk);
        chk("rx_valid", 32'(rx_valid), 32'(1'b1));
        chk("rx_data", 32'(rx_data), 32'(rxq[n-1]));
        last_rx = rxq[n-1];
    endtask

    task automatic rx_abort(input int k, input bit use_zero);
        step();
        for (int i = 0; i < k; i++) begin
            far_drive = 1'b1;
            far_pins  = {1'b1, 2'($urandom)};
            @(negedge clk);
            chk("abort_err_quiet", 32'(rx_err), 32'(1'b0));
            @(posedge clk);
            #1;
        end
        if (use_zero) far_pins = 3'b000;
        else          far_drive = 1'b0;
        @(negedge clk);
        chk("abort_err_early", 32'(rx_err), 32'(1'b0));
        @(posedge clk);
        #1;
        far_drive = 1'b0;
        @(negedge clk);
        chk("abort_err", 32'(rx_err), 32'(1'b1));
        chk("abort_no_valid", 32'(rx_valid), 32'(1'b0));
        chk("abort_rx_hold", 32'(rx_data), 32'(last_rx));
        chk("abort_idle", 32'(busy), 32'(1'b0));
        step();
        @(negedge clk);
        chk("abort_err_pulse", 32'(rx_err), 32'(1'b0));
    endtask

    task automatic collision(input logic [7:0] brx, input logic [7:0] btx);
        step();
        tx_data  = btx;
        tx_valid = 1'b1;
        rxq[0]   = brx;
        rx_stream(1);
        chk("coll_ready", 32'(tx_ready), 32'(1'b1));
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_observe(btx);
    endtask

    task automatic reset_mid_tx(input logic [7:0] b);
        step();
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("rst_tx_d0", 32'(iosig), 32'({1'b1, dib(b, 0)}));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tx_d1", 32'(iosig), 32'({1'b1, dib(b, 1)}));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_rx = 8'd0;
        @(negedge clk);
        chk("rst_tx_drive", 32'(drive), 32'(1'b0));
        chk("rst_tx_busy", 32'(busy), 32'(1'b0));
        chk("rst_tx_err", 32'(rx_err), 32'(1'b0));
        chk("rst_tx_rxdata", 32'(rx_data), 32'(8'h00));
        step();
        @(negedge clk);
        chk("rst_tx_err2", 32'(rx_err), 32'(1'b0));
        chk("rst_tx_ready", 32'(tx_ready), 32'(1'b1));
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            @(negedge clk);
            chk("idle_rx_hold", 32'(rx_data), 32'(last_rx));
            chk("idle_drive", 32'(drive), 32'(1'b0));
            chk("idle_busy", 32'(busy), 32'(1'b0));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int n;
        // Reset with the far end scribbling on the pins.
        far_drive = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            far_pins = 3'($urandom);
            @(negedge clk);
            chk("rst_drive", 32'(drive), 32'(1'b0));
            chk("rst_rxdata", 32'(rx_data), 32'(8'h00));
            chk("rst_valid", 32'(rx_valid), 32'(1'b0));
            chk("rst_err", 32'(rx_err), 32'(1'b0));
            chk("rst_busy", 32'(busy), 32'(1'b0));
        end
        far_drive = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(tx_ready), 32'(1'b1));

        // Directed cases.
        tx_byte(8'hB4);
        rxq[0] = 8'h4E;
        rxq[1] = 8'h00;
        step();
        rx_stream(2);
        rx_abort(2, 1'b1);
        collision(8'hC3, 8'h5A);
        reset_mid_tx(8'h96);
        idle_gap(2);

        // Randomised traffic.
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0: tx_byte(8'($urandom));
                1: begin
                    n = int'($urandom_range(1, 3));
                    for (int j = 0; j < n; j++) rxq[j] = 8'($urandom);
                    step();
                    rx_stream(n);
                end
                2: rx_abort(int'($urandom_range(1, 3)), 1'($urandom));
                3: collision(8'($urandom), 8'($urandom));
                default: idle_gap(int'($urandom_range(1, 3)));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
